acc_master: RTL and testbench
=============================

ACC_MASTER -- requirements
Module: acc_master

Interface
REQ-001 Parameter HASH_WAIT, default 80, idle cycles between the start write and the first hash read; legal range 1..1023.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 job_valid  input  1  job_block holds a 512-bit block to hash.
REQ-005 job_ready  output  1  block accepted on a cycle with job_valid && job_ready.
REQ-006 job_block  input  512  block; word k = job_block[32k+31:32k], k=0..15.
REQ-007 res_valid  output  1  res_hash holds a valid digest.
REQ-008 res_ready  input  1  consumer takes the digest on a cycle with res_valid && res_ready.
REQ-009 res_hash  output  256  digest; word k = res_hash[32k+31:32k], k=0..7.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 avm_address  output  5  accelerator word address.
REQ-012 avm_chipselect, avm_write, avm_read  output  1 each  Avalon-MM master strobes.
REQ-013 avm_writedata  output  32  write data.
REQ-014 avm_readdata  input  32  read data, fixed read latency 1, no waitrequest.

Function
REQ-015 FSM states: IDLE, CLR (only with the configuration macro), LOAD, START, WAIT, READ, ACK, DONE.
REQ-016 IDLE: job_ready=1; on accept, latch job_block, then go to CLR if compiled in, else LOAD.
REQ-017 CLR: one write of 32'hff0000ff to address 16, then LOAD.
REQ-018 LOAD: 16 consecutive single-cycle writes, address k = block word k, k=0..15 ascending.
REQ-019 START: one write of 32'hffffffff to address 16, then WAIT.
REQ-020 WAIT: bus idle for exactly HASH_WAIT cycles, counted by a down-counter, then READ.
REQ-021 READ: 8 back-to-back reads, addresses 0..7; readdata sampled one cycle after each read into res_hash word k.
REQ-022 ACK: one write of 32'h0f0f0f0f to address 16, issued in the same cycle as the capture of word 7; then DONE.
REQ-023 DONE: res_valid=1 and res_hash stable until res_ready; then IDLE, with job_ready asserted the following cycle and never in the same cycle.
REQ-024 avm_chipselect is high exactly when avm_write or avm_read is high; avm_write and avm_read are never high together; unused strobes and avm_writedata are 0.
REQ-025 Latency without the macro: res_valid rises 27+HASH_WAIT cycles after the accept edge; add 1 cycle with the macro.
REQ-026 job_valid outside IDLE is ignored; the latched block is unaffected by later job_block changes.

Reset
REQ-027 reset_n low asynchronously forces IDLE and clears all outputs to 0 except job_ready (0 during reset, 1 from the first clock after release); res_hash, the latched block and counters clear to 0.
REQ-028 Reset mid-transaction abandons the job with no further bus cycles and produces no result.

Configuration
REQ-029 Macro ACC_MASTER_CLR_EN: when defined, every job begins with the CLR write so that an accelerator left mid-job recovers; when undefined, CLR state and its logic are absent.

Structure
REQ-030 Package acc_pkg holds the state enum, ACC_CTRL_ADDR=16, the control words (START 32'hffffffff, CLR 32'hff0000ff, ACK 32'h0f0f0f0f), and word counts 16 and 8.
REQ-031 Single module, no sub-modules; the word index uses one 4-bit counter shared by LOAD and READ.

Verification
REQ-032 Block of word k = 32'h1000_0000+k, HASH_WAIT=4, no macro -> writes addr 0..15 with those values, addr 16 = ffffffff, 4 idle cycles, reads 0..7, ack 0f0f0f0f, res_valid at cycle 31 after accept.
REQ-033 Responder model returns 32'hA000_0000+addr one cycle late -> res_hash word k = 32'hA000_0000+k.
REQ-034 res_ready held low 20 cycles in DONE -> res_valid and res_hash stable, job_ready 0, bus idle; release -> IDLE next cycle.
REQ-035 reset_n pulsed low during READ word 3 -> all strobes 0 immediately, no ACK write, res_valid never asserts.
REQ-036 With ACC_MASTER_CLR_EN -> first write is ff0000ff to addr 16, latency 32 cycles at HASH_WAIT=4.
REQ-037 job_valid toggled while busy with a changed job_block -> ignored, written data match the first block.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the hash accelerator bus master: state encoding,
// control-register address, control words and block/digest word counts.
// Optional feature macro: ACC_MASTER_CLR_EN (adds the CLR state).
package acc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef ACC_MASTER_CLR_EN
    S_CLR,
`endif
    S_LOAD,
    S_START,
    S_WAIT,
    S_READ,
    S_ACK,
    S_DONE
  } state_t;

  localparam logic [4:0]  ACC_CTRL_ADDR  = 5'd16;
  localparam logic [31:0] ACC_START_WORD = 32'hffff_ffff;
  localparam logic [31:0] ACC_CLR_WORD   = 32'hff00_00ff;
  localparam logic [31:0] ACC_ACK_WORD   = 32'h0f0f_0f0f;
  localparam int          ACC_LOAD_WORDS = 16;
  localparam int          ACC_READ_WORDS = 8;

endpackage

// File: rtl/acc_master.sv
// Avalon-MM master that feeds one 512-bit block to a hash accelerator,
// waits a fixed time, reads back the 256-bit digest and acknowledges it.
// Optional feature macro: ACC_MASTER_CLR_EN -- every job starts with a
// clear write so an accelerator left mid-job is brought back to a known state.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | job_ready high, waiting for a block
// CLR    | clear word on the bus (only with ACC_MASTER_CLR_EN)
// LOAD   | block words 0..15 written to addresses 0..15
// START  | start word on the bus
// WAIT   | bus idle while the accelerator hashes (down-counter)
// READ   | digest reads 0..7, held here until word 7 is captured
// ACK    | acknowledge word on the bus
// DONE   | res_valid high until the consumer takes the digest
module acc_master
  import acc_pkg::*;
#(
  parameter int HASH_WAIT = 80
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [511:0] job_block,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [255:0] res_hash,
  output logic         busy,
  output logic [4:0]   avm_address,
  output logic         avm_chipselect,
  output logic         avm_write,
  output logic         avm_read,
  output logic [31:0]  avm_writedata,
  input  logic [31:0]  avm_readdata
);

  localparam logic [3:0] LOAD_LAST = 4'(ACC_LOAD_WORDS - 1);
  localparam logic [3:0] READ_LAST = 4'(ACC_READ_WORDS - 1);
  localparam logic [2:0] CAP_LAST  = 3'(ACC_READ_WORDS - 1);
  localparam logic [9:0] WAIT_INIT = 10'(HASH_WAIT - 1);

  state_t       state;
  logic [511:0] blk;
  logic [3:0]   idx;
  logic [3:0]   idx_inc;
  logic [9:0]   wait_cnt;
  // read pipeline tag: a read issued last cycle returns data this cycle
  logic         rd_q;
  logic [2:0]   rd_word_q;

  assign idx_inc = idx + 4'd1;

  // Sequencer: state, bus strobes, digest capture and handshakes, all registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      blk            <= '0;
      idx            <= '0;
      wait_cnt       <= '0;
      rd_q           <= 1'b0;
      rd_word_q      <= '0;
      job_ready      <= 1'b0;
      res_valid      <= 1'b0;
      res_hash       <= '0;
      busy           <= 1'b0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_writedata  <= '0;
    end else begin
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_writedata  <= '0;
      rd_q           <= avm_read;
      rd_word_q      <= avm_address[2:0];
      if (rd_q) res_hash[{rd_word_q, 5'b0} +: 32] <= avm_readdata;

      case (state)
        S_IDLE: begin
          if (job_valid && job_ready) begin
            blk            <= job_block;
            job_ready      <= 1'b0;
            busy           <= 1'b1;
            avm_chipselect <= 1'b1;
            avm_write      <= 1'b1;
`ifdef ACC_MASTER_CLR_EN
            state          <= S_CLR;
            avm_address    <= ACC_CTRL_ADDR;
            avm_writedata  <= ACC_CLR_WORD;
`else
            // word 0 goes out straight from the input; blk is not loaded yet
            state          <= S_LOAD;
            idx            <= '0;
            avm_writedata  <= job_block[31:0];
`endif
          end else begin
            job_ready <= 1'b1;
          end
        end
`ifdef ACC_MASTER_CLR_EN
        S_CLR: begin
          state          <= S_LOAD;
          idx            <= '0;
          avm_chipselect <= 1'b1;
          avm_write      <= 1'b1;
          avm_writedata  <= blk[31:0];
        end
`endif
        S_LOAD: begin
          avm_chipselect <= 1'b1;
          avm_write      <= 1'b1;
          if (idx == LOAD_LAST) begin
            state         <= S_START;
            avm_address   <= ACC_CTRL_ADDR;
            avm_writedata <= ACC_START_WORD;
          end else begin
            idx           <= idx_inc;
            avm_address   <= {1'b0, idx_inc};
            avm_writedata <= blk[{idx_inc, 5'b0} +: 32];
          end
        end
        S_START: begin
          state    <= S_WAIT;
          wait_cnt <= WAIT_INIT;
        end
        S_WAIT: begin
          if (wait_cnt == 10'd0) begin
            state          <= S_READ;
            idx            <= '0;
            avm_chipselect <= 1'b1;
            avm_read       <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 10'd1;
          end
        end
        S_READ: begin
          if (idx != READ_LAST) begin
            idx            <= idx_inc;
            avm_chipselect <= 1'b1;
            avm_read       <= 1'b1;
            avm_address    <= {1'b0, idx_inc};
          end
          // the ack goes out on the same edge that captures the last word
          if (rd_q && rd_word_q == CAP_LAST) begin
            state          <= S_ACK;
            avm_chipselect <= 1'b1;
            avm_write      <= 1'b1;
            avm_address    <= ACC_CTRL_ADDR;
            avm_writedata  <= ACC_ACK_WORD;
          end
        end
        S_ACK: begin
          state     <= S_DONE;
          res_valid <= 1'b1;
        end
        S_DONE: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_master.sv
// Directed bench for acc_master: expected bus transactions are queued when a
// job is driven and popped by a bus monitor; a one-cycle-latency responder
// returns 32'hA000_0000 + address.
module tb_acc_master;

  localparam int HW = 4;
`ifdef ACC_MASTER_CLR_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif
  localparam int LAT = 27 + HW + PRE;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         job_valid;
  logic         job_ready;
  logic [511:0] job_block;
  logic         res_valid;
  logic         res_ready;
  logic [255:0] res_hash;
  logic         busy;
  logic [4:0]   avm_address;
  logic         avm_chipselect;
  logic         avm_write;
  logic         avm_read;
  logic [31:0]  avm_writedata;
  logic [31:0]  avm_readdata = '0;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [4:0]  addr;
    logic [31:0] data;
  } bus_t;

  bus_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   start_cyc = -1, read0_cyc = -1, ack_cyc = -1;

  acc_master #(.HASH_WAIT(HW)) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_block(job_block),
    .res_valid(res_valid), .res_ready(res_ready), .res_hash(res_hash),
    .busy(busy), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // accelerator responder: fixed read latency of one cycle
  always @(posedge clk)
    avm_readdata <= (avm_chipselect && avm_read) ? 32'hA000_0000 + {27'd0, avm_address} : 32'd0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bus monitor: protocol rules plus in-order scoreboard of transactions
  always @(negedge clk) begin
    bus_t e;
    if (avm_chipselect || avm_write || avm_read) begin
      check("bus_cs", 256'(avm_chipselect), 256'(avm_write | avm_read));
      check("bus_excl", 256'(avm_write & avm_read), 256'(0));
      check("bus_expected_pending", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("bus_txn", 256'({avm_write, avm_read, avm_address, avm_writedata}), 256'(e));
      end
      if (avm_write && avm_address == 5'd16 && avm_writedata == 32'hffff_ffff) start_cyc = cyc;
      if (avm_write && avm_address == 5'd16 && avm_writedata == 32'h0f0f_0f0f) ack_cyc = cyc;
      if (avm_read && avm_address == 5'd0) read0_cyc = cyc;
    end else begin
      check("idle_wdata", 256'(avm_writedata), 256'(0));
    end
  end

  task automatic push_job(input logic [511:0] b);
`ifdef ACC_MASTER_CLR_EN
    exp_q.push_back('{1'b1, 1'b0, 5'd16, 32'hff00_00ff});
`endif
    for (int k = 0; k < 16; k++) exp_q.push_back('{1'b1, 1'b0, 5'(k), b[32*k +: 32]});
    exp_q.push_back('{1'b1, 1'b0, 5'd16, 32'hffff_ffff});
    for (int k = 0; k < 8; k++) exp_q.push_back('{1'b0, 1'b1, 5'(k), 32'd0});
    exp_q.push_back('{1'b1, 1'b0, 5'd16, 32'h0f0f_0f0f});
  endtask

  task automatic accept_job(input logic [511:0] b, output int acc);
    int n = 0;
    while (!job_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("job_ready_before_accept", 256'(job_ready), 256'(1));
    push_job(b);
    job_block = b;
    job_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    job_valid = 1'b0;
    check("accept_busy", 256'(busy), 256'(1));
    check("accept_job_ready_low", 256'(job_ready), 256'(0));
  endtask

  task automatic wait_result(input int acc);
    int n = 0;
    while (!res_valid && n < LAT + 20) begin @(posedge clk); #1; n++; end
    check("latency", 256'(cyc - acc), 256'(LAT));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] blk_a, blk_b, blk_c, blk_d;
    logic [255:0] exp_h;
    int  acc;
    int  n;
    bit  found;
    bit  rv_seen;

    for (int k = 0; k < 16; k++) blk_a[32*k +: 32] = 32'h1000_0000 + k;
    for (int k = 0; k < 16; k++) begin
      blk_b[32*k +: 32] = $urandom;
      blk_c[32*k +: 32] = $urandom;
      blk_d[32*k +: 32] = $urandom;
    end
    for (int k = 0; k < 8; k++) exp_h[32*k +: 32] = 32'hA000_0000 + k;

    reset_n = 1'b0; job_valid = 1'b0; job_block = '0; res_ready = 1'b0;
    #1;
    check("reset_outputs", 256'({job_ready, res_valid, busy, avm_chipselect, avm_write,
                                 avm_read, avm_address, avm_writedata}), 256'(0));
    check("reset_hash", res_hash, 256'(0));
    @(posedge clk); @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", 256'({job_ready, busy}), 256'(2'b10));

    // job A: known block, digest held 20 cycles before the consumer takes it
    accept_job(blk_a, acc);
    wait_result(acc);
    check("a_start_cycle", 256'(start_cyc - acc), 256'(16 + PRE));
    check("a_wait_gap", 256'(read0_cyc - start_cyc), 256'(HW + 1));
    check("a_ack_cycle", 256'(ack_cyc - acc), 256'(LAT - 1));
    check("a_hash", res_hash, exp_h);
    check("a_queue_empty", 256'(exp_q.size()), 256'(0));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("a_hold_valid", 256'({res_valid, busy, job_ready}), 256'(3'b110));
      check("a_hold_hash", res_hash, exp_h);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("a_release", 256'({res_valid, busy, job_ready}), 256'(3'b000));
    @(posedge clk); #1;
    check("a_ready_next", 256'(job_ready), 256'(1));

    // job B: job_valid toggled with a different block while busy
    accept_job(blk_b, acc);
    for (int i = 0; i < 12; i++) begin
      job_valid = i[0];
      job_block = ~blk_b ^ 512'(i);
      @(posedge clk); #1;
    end
    job_valid = 1'b0;
    wait_result(acc);
    check("b_hash", res_hash, exp_h);
    @(posedge clk); #1;
    check("b_done_exit", 256'({res_valid, busy}), 256'(0));
    check("b_queue_empty", 256'(exp_q.size()), 256'(0));

    // job C: reset pulsed during the read of digest word 3
    accept_job(blk_c, acc);
    found = 1'b0;
    n = 0;
    while (!found && n < LAT + 20) begin
      @(posedge clk); #1; n++;
      found = avm_read && avm_address == 5'd3;
    end
    check("c_read3_reached", 256'(found), 256'(1));
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("c_reset_outputs", 256'({job_ready, res_valid, busy, avm_chipselect, avm_write,
                                   avm_read, avm_writedata}), 256'(0));
    check("c_reset_hash", res_hash, 256'(0));
    @(posedge clk); @(posedge clk); #3;
    reset_n = 1'b1;
    rv_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      rv_seen = rv_seen | res_valid;
    end
    check("c_no_result", 256'(rv_seen), 256'(0));
    check("c_idle_ready", 256'({job_ready, busy}), 256'(2'b10));

    // job D: recovery after the abandoned job, consumer always ready
    accept_job(blk_d, acc);
    wait_result(acc);
    check("d_hash", res_hash, exp_h);
    @(posedge clk); #1;
    check("d_done_exit", 256'({res_valid, busy, job_ready}), 256'(0));
    @(posedge clk); #1;
    check("d_ready_next", 256'(job_ready), 256'(1));
    check("d_queue_empty", 256'(exp_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
